// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
//   fetch_entry_t : one prefetch FIFO entry, {pc, instr}
//   INSTR_BYTES   : PC increment per fetched word
//   NOP_INSTR     : canonical no-op (addi x0,x0,0), used as the storage reset value
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : entry to write
//   pop        : remove head (ignored when empty)
//   flush      : discard all entries; takes priority over push
//   head       : entry at the read pointer, read straight from storage
//   count      : number of valid entries (0..DEPTH)
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_en;
  logic           push_en;

  always_comb begin
    pop_en  = pop && (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_en = push && !flush && ((count != FULL) || pop_en);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_en);
      rd_ptr <= rd_ptr + AW'(pop_en);
      count  <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues in-order word requests
// to instruction memory, buffers returned words in a prefetch FIFO and hands
// {pc, instr} to decode. Redirects from execute flush the FIFO and discard
// every response still in flight.
// Optional feature: define FETCH_PERF_EN to add saturating perf counters.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   redirect_valid, redirect_pc      : PC change request from execute
//   imem_req_valid/addr/ready        : fetch request channel
//   imem_resp_valid/data             : in-order response channel (no stall)
//   instr_valid/instr/instr_pc/ready : FIFO head towards decode
//   perf_fetched, perf_redirects     : (FETCH_PERF_EN only) words pushed / redirects seen
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned I_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [D_WIDTH-1:0] redirect_pc,
  output logic               imem_req_valid,
  output logic [D_WIDTH-1:0] imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [I_WIDTH-1:0] imem_resp_data,
  output logic               instr_valid,
  output logic [I_WIDTH-1:0] instr,
  output logic [D_WIDTH-1:0] instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [D_WIDTH-1:0] PC_STEP = D_WIDTH'(INSTR_BYTES);

  logic [D_WIDTH-1:0] pc;
  logic [D_WIDTH-1:0] resp_pc;
  logic [D_WIDTH-1:0] redirect_target;
  logic [CW-1:0]      out_cnt;
  logic [CW-1:0]      out_cnt_next;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        occupancy;
  logic               req_fire;
  logic               resp_fire;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  always_comb begin
    redirect_target = redirect_pc & ~(PC_STEP - D_WIDTH'(1));
    // Words already buffered plus live (non-dropped) requests in flight.
    occupancy       = {1'b0, fifo_cnt} + {1'b0, out_cnt} - {1'b0, drop_cnt};
    imem_req_valid  = !rst && !redirect_valid && (occupancy < CREDIT_MAX);
    req_fire        = imem_req_valid && imem_req_ready;
    resp_fire       = imem_resp_valid && (out_cnt != '0);
    out_cnt_next    = out_cnt + CW'(req_fire) - CW'(resp_fire);
    push            = resp_fire && !redirect_valid && (drop_cnt == '0);
    pop             = instr_valid && instr_ready;
    push_entry.pc    = resp_pc;
    push_entry.instr = imem_resp_data;
  end

  // resp_pc is the PC of the next response that will be kept. Live requests
  // are always a contiguous run starting at the last redirect target, so a
  // single running address replaces a per-request shadow queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      out_cnt <= out_cnt_next;
      if (redirect_valid) begin
        pc       <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= out_cnt_next;
      end else begin
        if (req_fire) pc <= pc + PC_STEP;
        if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) resp_pc <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (fifo_cnt)
  );

  assign imem_req_addr = pc;
  assign instr_valid   = (fifo_cnt != '0);
  assign instr         = head.instr;
  assign instr_pc      = head.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

  resp_needs_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (out_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  fetch_unit #(
    .D_WIDTH   (32),
    .I_WIDTH   (32),
    .FIFO_DEPTH(DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the memory holds requests in order with a due cycle and a
  // "dropped" tag; decode sees exactly the kept words in address order.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          dropped;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_req;
  int unsigned cyc;
  int unsigned lat;
  int unsigned last_due;
  int unsigned pf;
  int unsigned pr;
  int unsigned total;
  int unsigned bad;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic int unsigned live_cnt();
    int unsigned n = 0;
    foreach (mem_q[i]) if (!mem_q[i].dropped) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    mem_q.delete();
    exp_req  = RST_PC;
    last_due = cyc;
    pf = 0;
    pr = 0;
  endtask

  task automatic do_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      rst = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      instr_ready     = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_req_valid", imem_req_valid, 0);
      if (i > 0) begin
        check("rst_instr_valid", instr_valid, 0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 0);
        check("rst_perf_redirects", perf_redirects, 0);
`endif
      end
    end
  endtask

  task automatic do_cycle(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit i_rdy);
    bit          rv;
    bit          exp_rv;
    int unsigned occ;
    int unsigned due;
    mreq_t       e;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = rq_rdy;
    instr_ready     = i_rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rv ? word_of(mem_q[0].addr) : $urandom;
    @(negedge clk);
    occ    = fifo_q.size() + live_cnt();
    exp_rv = !redir && (occ < DEPTH);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, exp_req);
    check("instr_valid", instr_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      check("instr_pc", instr_pc, fifo_q[0]);
      check("instr", instr, word_of(fifo_q[0]));
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, pf);
    check("perf_redirects", perf_redirects, pr);
`endif
    if ((fifo_q.size() != 0) && i_rdy) void'(fifo_q.pop_front());
    if (rv) begin
      e = mem_q.pop_front();
      if (!redir && !e.dropped) begin
        fifo_q.push_back(e.addr);
        pf++;
      end
    end
    if (exp_rv && rq_rdy) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{addr: exp_req, due: due, dropped: 1'b0});
      last_due = due;
      exp_req  = exp_req + 32'd4;
    end
    if (redir) begin
      fifo_q.delete();
      foreach (mem_q[i]) mem_q[i].dropped = 1'b1;
      exp_req = rpc & ~32'd3;
      pr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    bit          held;
    bit          rdy;
    logic [31:0] held_addr;
    total = 0; bad = 0; cyc = 0; lat = 1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
    model_reset();
    do_reset(3);

    // Streaming with 1-cycle memory
    lat = 1;
    do_cycle(0, 0, 1, 1);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RST_PC);
    do_cycle(0, 0, 1, 1);
    do_cycle(0, 0, 1, 1);
    check("first_instr_valid", instr_valid, 1);
    check("first_instr_pc", instr_pc, RST_PC);
    repeat (15) do_cycle(0, 0, 1, 1);

    // Decode stall: FIFO fills and requests stop
    repeat (10) do_cycle(0, 0, 1, 0);
    check("stall_head_valid", instr_valid, 1);
    check("stall_no_req", imem_req_valid, 0);
    repeat (10) do_cycle(0, 0, 1, 1);

    // Memory backpressure with variable latency: address held until accepted
    held = 1'b0; held_addr = '0;
    repeat (40) begin
      lat = $urandom_range(1, 3);
      rdy = 1'($urandom_range(0, 1));
      do_cycle(0, 0, rdy, 1);
      if (held && imem_req_valid) check("hold_addr", imem_req_addr, held_addr);
      held = imem_req_valid && !rdy;
      held_addr = imem_req_addr;
    end

    // Redirect to 0x103 with two live requests in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      do_cycle(0, 0, 1, 1);
      found = (live_cnt() == 2) && (fifo_q.size() == 0);
    end
    check("setup_two_inflight", found, 1);
    do_cycle(1, 32'h0000_0103, 1, 1);
    do_cycle(0, 0, 1, 1);
    check("redir_req_valid", imem_req_valid, 1);
    check("redir_addr", imem_req_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(0, 0, 1, 1);
      found = instr_valid;
    end
    check("redir_instr_seen", found, 1);
    if (found) check("redir_first_pc", instr_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(0, 0, 1, 1);
      found = (fifo_q.size() != 0) && (mem_q.size() != 0) && (mem_q[0].due == cyc + 1);
    end
    check("setup_resp_pop", found, 1);
    do_cycle(1, 32'h0000_0200, 1, 1);
    check("redir_pop_valid", instr_valid, 1);
    do_cycle(0, 0, 1, 1);
    check("flush_empty", instr_valid, 0);
    repeat (6) do_cycle(0, 0, 1, 1);

    // PC wrap
    do_cycle(1, 32'hFFFF_FFFC, 1, 1);
    do_cycle(0, 0, 1, 1);
    check("wrap_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
    do_cycle(0, 0, 1, 1);
    check("wrap_req_valid", imem_req_valid, 1);
    check("wrap_addr_lo", imem_req_addr, 32'h0000_0000);
    repeat (6) do_cycle(0, 0, 1, 1);

    // Random traffic
    repeat (400) begin
      lat = $urandom_range(1, 4);
      do_cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 3) != 0);
    end

    // Reset mid-operation
    do_reset(2);
    lat = 1;
    do_cycle(0, 0, 1, 1);
    check("rerst_req_valid", imem_req_valid, 1);
    check("rerst_req_addr", imem_req_addr, RST_PC);
    repeat (12) do_cycle(0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
